// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encoding,
// special instruction words and the byte-assembly helper.
package fetch_pkg;

  // Visible FSM states. HALT is not a separate encoding: it is RUN with the
  // halt flag set, so o_state keeps showing RUN while o_halt reports the stop.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2,
    ST_RUN   = 2'd3
  } fetch_state_e;

  localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

  // Four bytes per word, so the byte counter is two bits wide.
  localparam int BYTE_CNT_W = 2;

  // Place a byte into a big-endian word: index 0 lands in bits 31:24.
  function automatic logic [31:0] insert_byte(input logic [31:0]           word,
                                               input logic [7:0]            b,
                                               input logic [BYTE_CNT_W-1:0] idx);
    logic [4:0] shamt;
    shamt = {2'd3 - idx, 3'b000};
    return word | (32'(b) << shamt);
  endfunction

endpackage

// File: rtl/instr_mem.sv
// Instruction memory: MEM_DEPTH x 32, one synchronous write port and one
// asynchronous read port. Contents survive reset.
module instr_mem #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_W    = $clog2(MEM_DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [31:0]       i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [31:0]       o_rd_data
);

  logic [31:0] r_mem [MEM_DEPTH];

  // Write port: store one word per enabled clock.
  // NOTE: the array deliberately has no reset branch; a program loaded once
  // must survive a reset, and a resettable array would also stop it mapping
  // onto RAM.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/instr_fetch_unit.sv
// MIPS instruction-fetch stage: loads the program from the debug unit as a
// big-endian byte stream, fetches the word addressed by the PC into the IF/ID
// register with stall/flush control, drives the PC write enable and stops on
// the HALT instruction.
// Build option: define HALT_DETECT_EN to enable HALT detection; without it
// o_halt is tied low and 0xFFFFFFFF is fetched like any other word.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int NBITS     = 32,
  parameter int MEM_DEPTH = 256,
  localparam int ADDR_W   = $clog2(MEM_DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NBITS-1:0]  i_pc,
  input  logic [NBITS-1:0]  i_pc_4,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic [7:0]        i_load_byte,
  input  logic              i_load_valid,
  input  logic              i_load_done,
  input  logic              i_run,
  output logic              o_pc_wr_en,
  output logic [31:0]       o_instr,
  output logic [NBITS-1:0]  o_pc_4,
  output logic              o_valid,
  output logic              o_halt,
  output logic [1:0]        o_state,
  output logic [ADDR_W:0]   o_load_count
);

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(MEM_DEPTH);

  fetch_state_e          r_state;
  logic                  r_halt;
  logic [BYTE_CNT_W-1:0] r_byte_cnt;
  logic [31:0]           r_word;
  logic [ADDR_W:0]       r_load_count;
  logic [31:0]           r_instr;
  logic [NBITS-1:0]      r_pc_4;
  logic                  r_valid;

  logic                  w_take_byte;
  logic                  w_word_full;
  logic                  w_partial;
  logic                  w_commit;
  logic                  w_room;
  logic                  w_mem_we;
  logic [31:0]           w_asm;
  logic [31:0]           w_commit_data;
  logic [ADDR_W-1:0]     w_rd_addr;
  logic [31:0]           w_rd_data;
  logic                  w_pc_bad;
  logic [31:0]           w_fetch;

  // Byte assembly: a byte is accepted in IDLE (it starts the load) or LOAD.
  assign w_take_byte   = i_load_valid && (r_state == ST_IDLE || r_state == ST_LOAD);
  assign w_asm         = insert_byte(r_word, i_load_byte, r_byte_cnt);
  assign w_word_full   = w_take_byte && (r_byte_cnt == 2'd3);
  // End of stream with an incomplete word: the byte arriving with done counts.
  assign w_partial     = (r_state == ST_LOAD) && i_load_done && !w_word_full &&
                         (w_take_byte || (r_byte_cnt != '0));
  assign w_commit      = w_word_full || w_partial;
  assign w_commit_data = w_take_byte ? w_asm : r_word;
  // Words beyond the end of memory are dropped and the count stops at depth.
  assign w_room        = (r_load_count < DEPTH_CNT);
  assign w_mem_we      = w_commit && w_room;

  // Fetch path: misaligned or out-of-range PCs read as HALT_INSTR.
  assign w_rd_addr = i_pc[ADDR_W+1:2];
  assign w_pc_bad  = (|i_pc[NBITS-1:ADDR_W+2]) || (|i_pc[1:0]);
  assign w_fetch   = w_pc_bad ? HALT_INSTR : w_rd_data;

  instr_mem #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_W    (ADDR_W)
  ) u_instr_mem (
    .i_clk     (i_clk),
    .i_wr_en   (w_mem_we),
    .i_wr_addr (r_load_count[ADDR_W-1:0]),
    .i_wr_data (w_commit_data),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  // FSM, load assembler and IF/ID register in one sequential process.
  // NOTE: all state here uses non-blocking assignment so every register samples
  // pre-edge values; blocking assignment would let later statements see
  // already-updated state and change behaviour with statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_halt       <= 1'b0;
      r_byte_cnt   <= '0;
      r_word       <= '0;
      r_load_count <= '0;
      r_instr      <= NOP_INSTR;
      r_pc_4       <= '0;
      r_valid      <= 1'b0;
    end else begin
      if (w_take_byte) begin
        r_byte_cnt <= r_byte_cnt + 2'd1;
        r_word     <= w_word_full ? '0 : w_asm;
      end
      if (w_mem_we) begin
        r_load_count <= r_load_count + (ADDR_W+1)'(1);
      end

      case (r_state)
        ST_IDLE: begin
          if (i_load_valid) begin
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (i_load_done) begin
            r_byte_cnt <= '0;
            r_word     <= '0;
            r_state    <= ST_READY;
          end
        end
        ST_READY: begin
          if (i_run) begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!r_halt) begin
            if (i_flush) begin
              r_instr <= NOP_INSTR;
              r_valid <= 1'b0;
            end else if (!i_stall) begin
              r_instr <= w_fetch;
              r_pc_4  <= i_pc_4;
              r_valid <= 1'b1;
`ifdef HALT_DETECT_EN
              if (w_fetch == HALT_INSTR) begin
                r_halt <= 1'b1;
              end
`endif
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_pc_wr_en   = (r_state == ST_RUN) && !r_halt && !i_stall;
  assign o_instr      = r_instr;
  assign o_pc_4       = r_pc_4;
  assign o_valid      = r_valid;
  assign o_state      = r_state;
  assign o_load_count = r_load_count;
`ifdef HALT_DETECT_EN
  assign o_halt       = r_halt;
`else
  assign o_halt       = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a queue/array model of the fetch
// stage, a per-cycle compare process and a few literal expectations.
module tb_instr_fetch_unit;

  localparam int DEPTH = 256;
  localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] pc_4;
  logic        stall;
  logic        flush;
  logic [7:0]  load_byte;
  logic        load_valid;
  logic        load_done;
  logic        run;
  logic        o_pc_wr_en;
  logic [31:0] o_instr;
  logic [31:0] o_pc_4;
  logic        o_valid;
  logic        o_halt;
  logic [1:0]  o_state;
  logic [8:0]  o_load_count;

  instr_fetch_unit #(.NBITS(32), .MEM_DEPTH(DEPTH)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_pc         (pc),
    .i_pc_4       (pc_4),
    .i_stall      (stall),
    .i_flush      (flush),
    .i_load_byte  (load_byte),
    .i_load_valid (load_valid),
    .i_load_done  (load_done),
    .i_run        (run),
    .o_pc_wr_en   (o_pc_wr_en),
    .o_instr      (o_instr),
    .o_pc_4       (o_pc_4),
    .o_valid      (o_valid),
    .o_halt       (o_halt),
    .o_state      (o_state),
    .o_load_count (o_load_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_state;   // 0 idle, 1 load, 2 ready, 3 run
  bit          m_halt;
  logic [7:0]  m_q[$];    // bytes of the word being loaded
  logic [31:0] m_mem[DEPTH];
  bit          m_known[DEPTH];
  int          m_count;
  logic [31:0] m_instr;
  bit          m_valid;
  logic [31:0] m_pc4;
  bit          m_iknown;
  bit          m_started = 1'b0;

  function automatic void m_commit();
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < m_q.size(); i++) w[31-8*i -: 8] = m_q[i];
    if (m_count < DEPTH) begin
      m_mem[m_count]   = w;
      m_known[m_count] = 1'b1;
      m_count++;
    end
    m_q.delete();
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_state = 0; m_halt = 1'b0; m_q.delete(); m_count = 0;
      m_instr = '0; m_valid = 1'b0; m_pc4 = '0; m_iknown = 1'b1; m_started = 1'b1;
    end else begin
      case (m_state)
        0: if (load_valid) begin m_q.push_back(load_byte); m_state = 1; end
        1: begin
          if (load_valid) begin
            m_q.push_back(load_byte);
            if (m_q.size() == 4) m_commit();
          end
          if (load_done) begin
            if (m_q.size() > 0) m_commit();
            m_state = 2;
          end
        end
        2: if (run) m_state = 3;
        default: if (!m_halt) begin
          if (flush) begin
            m_instr = '0; m_valid = 1'b0; m_iknown = 1'b1;
          end else if (!stall) begin
            if (pc % 4 != 0 || pc >= 4 * DEPTH) begin
              m_instr = HALT_W; m_iknown = 1'b1;
            end else if (m_known[pc / 4]) begin
              m_instr = m_mem[pc / 4]; m_iknown = 1'b1;
            end else begin
              m_iknown = 1'b0;
            end
            m_valid = 1'b1;
            m_pc4   = pc_4;
`ifdef HALT_DETECT_EN
            if (m_iknown && m_instr == HALT_W) m_halt = 1'b1;
`endif
          end
        end
      endcase
    end
  end

  // Compare process: outputs checked mid-cycle on every cycle after reset.
  always @(negedge clk) begin
    if (m_started) begin
      check("state", 32'(o_state), m_state);
      check("load_count", 32'(o_load_count), m_count);
      check("valid", 32'(o_valid), 32'(m_valid));
      if (m_iknown) check("instr", o_instr, m_instr);
      if (m_valid) check("pc_4", o_pc_4, m_pc4);
      check("halt", 32'(o_halt), 32'(m_halt));
      check("pc_wr_en", 32'(o_pc_wr_en), 32'(m_state == 3 && !m_halt && !stall));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    load_valid = 1'b1; load_byte = b; tick(); load_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8]);
  endtask

  task automatic finish_load();
    load_done = 1'b1; tick(); load_done = 1'b0;
  endtask

  task automatic start_run();
    run = 1'b1; tick(); run = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a, input logic st, input logic fl);
    pc = a; pc_4 = a + 32'd4; stall = st; flush = fl; tick();
  endtask

  function automatic logic [31:0] rand_pc();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return {22'($urandom_range(0, 255)), 2'b00} | 32'($urandom_range(1, 3));
    if (r == 1) return 32'(4 * DEPTH) + {($urandom % 32'h4000), 2'b00};
    return {22'($urandom_range(0, DEPTH - 1)), 2'b00};
  endfunction

  initial begin
    rst = 1'b1; pc = '0; pc_4 = 32'd4; stall = 1'b0; flush = 1'b0;
    load_byte = '0; load_valid = 1'b0; load_done = 1'b0; run = 1'b0;
    tick();
    do_reset();

    // Reset values.
    check("rst_state", 32'(o_state), 32'd0);
    check("rst_instr", o_instr, 32'd0);
    check("rst_count", 32'(o_load_count), 32'd0);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_pc_wr_en", 32'(o_pc_wr_en), 32'd0);
    check("rst_halt", 32'(o_halt), 32'd0);

    // Two full words, big-endian.
    send_word(32'h1234_5678);
    send_word(32'hABCD_EF01);
    finish_load();
    check("load2_count", 32'(o_load_count), 32'd2);
    check("load2_state", 32'(o_state), 32'd2);
    check("model_mem0", m_mem[0], 32'h1234_5678);
    check("model_mem1", m_mem[1], 32'hABCD_EF01);
    start_run();
    check("run_state", 32'(o_state), 32'd3);
    check("run_pc_wr_en", 32'(o_pc_wr_en), 32'd1);
    fetch(32'd0, 1'b0, 1'b0);
    check("fetch0_instr", o_instr, 32'h1234_5678);
    check("fetch0_pc4", o_pc_4, 32'd4);
    check("fetch0_valid", 32'(o_valid), 32'd1);
    fetch(32'd4, 1'b0, 1'b0);
    check("fetch4_instr", o_instr, 32'hABCD_EF01);
    check("fetch4_pc4", o_pc_4, 32'd8);
    // Stall two cycles: IF/ID holds, PC write disabled.
    fetch(32'd0, 1'b1, 1'b0);
    fetch(32'd0, 1'b1, 1'b0);
    check("stall_instr", o_instr, 32'hABCD_EF01);
    check("stall_pc_wr_en", 32'(o_pc_wr_en), 32'd0);
    // Flush wins over stall.
    fetch(32'd0, 1'b1, 1'b1);
    check("flush_instr", o_instr, 32'd0);
    check("flush_valid", 32'(o_valid), 32'd0);
    stall = 1'b0; flush = 1'b0;

    // Partial word padded with zeros.
    do_reset();
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    finish_load();
    check("partial_count", 32'(o_load_count), 32'd1);
    check("model_partial", m_mem[0], 32'h1122_3300);
    start_run();
    fetch(32'd0, 1'b0, 1'b0);
    check("partial_instr", o_instr, 32'h1122_3300);

    // HALT word at index 2; a flushed HALT must not stop execution.
    do_reset();
    send_word(32'h0102_0304);
    send_word(32'h0506_0708);
    send_word(HALT_W);
    finish_load();
    start_run();
    fetch(32'd0, 1'b0, 1'b0);
    fetch(32'd4, 1'b0, 1'b0);
    fetch(32'd8, 1'b0, 1'b1);
    check("flushed_halt", 32'(o_halt), 32'd0);
    fetch(32'd8, 1'b0, 1'b0);
    check("halt_instr", o_instr, HALT_W);
    fetch(32'd0, 1'b0, 1'b0);
`ifdef HALT_DETECT_EN
    check("halt_flag", 32'(o_halt), 32'd1);
    check("halt_pc_wr_en", 32'(o_pc_wr_en), 32'd0);
    check("halt_hold", o_instr, HALT_W);
`else
    check("nohalt_flag", 32'(o_halt), 32'd0);
    check("nohalt_pc_wr_en", 32'(o_pc_wr_en), 32'd1);
    check("nohalt_continue", o_instr, 32'h0102_0304);
`endif

    // Reset mid-load discards the partial word.
    do_reset();
    send_byte(8'hAA); send_byte(8'hBB);
    do_reset();
    send_word(32'hDEAD_BEEF);
    finish_load();
    check("reload_count", 32'(o_load_count), 32'd1);
    start_run();
    fetch(32'd0, 1'b0, 1'b0);
    check("reload_instr", o_instr, 32'hDEAD_BEEF);

    // Overflow: more than MEM_DEPTH words, count saturates.
    do_reset();
    for (int i = 0; i < 4 * DEPTH + 6; i++) send_byte(8'($urandom));
    finish_load();
    check("sat_count", 32'(o_load_count), 32'(DEPTH));

    // Randomized load/run sessions.
    for (int it = 0; it < 40; it++) begin
      int nb;
      do_reset();
      nb = $urandom_range(0, 24);
      for (int b = 0; b < nb; b++) begin
        repeat ($urandom_range(0, 2)) tick();
        if (b == nb - 1 && $urandom_range(0, 1) == 1) begin
          load_done = 1'b1; send_byte(8'($urandom)); load_done = 1'b0;
        end else begin
          send_byte(8'($urandom));
        end
      end
      finish_load();
      repeat ($urandom_range(0, 2)) tick();
      start_run();
      for (int c = 0; c < 30; c++) begin
        fetch(rand_pc(), ($urandom_range(0, 3) == 0), ($urandom_range(0, 6) == 0));
      end
      stall = 1'b0; flush = 1'b0;
    end

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
